ltssm_main_sequencer: RTL and testbench
=======================================

Name: ltssm_main_sequencer

Overview:
- Top-level LTSSM controller that sequences the master RX and master TX sub-LTSSMs. It issues one training substate at a time on a shared `substate` bus and collects both `finish`/`exitTo` responses.
- From those responses it decides the next substate, counts failed training attempts and reports link status.
- It sits between the LPIF control interface and the RX/TX sub-LTSSMs, which share the per-substate timer.

Parameters:
- MAX_RETRIES, 8: consecutive failed attempts before declaring link failure (1..15).
- WD_WIDTH, 24: watchdog counter width. A wait times out at 2^WD_WIDTH-1 cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startLtssm  in  1  level; begin training from IDLE/FAILED
- forceDetect  in  1  pulse; abandon current substate, restart at detectQuiet
- numberOfDetectedLanes  in  5  lane count from detect logic; valid when detectActive finishes
- rxFinish  in  1  RX sub-LTSSM done pulse
- rxExitTo  in  4  RX requested next substate; valid with rxFinish
- txFinish  in  1  TX sub-LTSSM done pulse
- txExitTo  in  4  TX requested next substate; valid with txFinish
- substate  out  4  substate issued to RX/TX; 4'hF = no request
- activeLanes  out  5  lane count latched at detectActive success
- linkUp  out  1  high while in L0
- lpifStatus  out  4  0 = idle, 1 = training, 2 = active (L0), 3 = link failed
- failCount  out  4  consecutive failed attempts

Behaviour:
Substate encoding (shared package): detectQuiet 0, detectActive 1, pollingActive 2, pollingConfiguration 3, cfgLinkWidthStart 4, cfgLinkWidthAccept 5, cfgLanenumWait 6, cfgLanenumAccept 7, cfgComplete 8, cfgIdle 9, L0 10, NONE 4'hF.

Reset (synchronous, active-high) applies in any state, mid-operation included. Reset values:
- state = IDLE, substate = 4'hF, target = detectQuiet
- rxDone/txDone flags, captured exitTo and watchdog = 0
- activeLanes = 0, linkUp = 0, lpifStatus = 0, failCount = 0

States:
- IDLE: substate = F, lpifStatus = 0. If startLtssm, go to GAP with target = detectQuiet.
- GAP (exactly 1 cycle): substate = F, so consumers see a new request even when the same substate is reissued. Clear flags and watchdog, then go to WAIT. lpifStatus = 1.
- WAIT: substate = target; watchdog increments each cycle.
  - rxFinish sets rxDone and captures rxExitTo; txFinish likewise. Same-cycle finishes are both captured.
  - A finish pulse while its done flag is already set is ignored; the first capture wins.
  - When both flags are set, go to DECIDE.
  - Watchdog at terminal count without both flags: fail.
- DECIDE (1 cycle, substate held at target):
  - Success means rxExit == txExit == target+1, with target < cfgIdle. Then next target = target+1.
  - Success from detectActive latches activeLanes = numberOfDetectedLanes. If that value is not in {1, 2, 4, 8, 16}, treat it as fail.
  - Success from cfgIdle (both exit == L0): go to LINK, failCount = 0.
  - Any other combination (either exit = 0, or a mismatch) is a fail.
- Fail handling: failCount+1. If the result equals MAX_RETRIES, go to FAILED; otherwise go to GAP with target = detectQuiet.
- LINK: substate = L0, linkUp = 1, lpifStatus = 2. Finish pulses are ignored.
- FAILED: substate = F, lpifStatus = 3, linkUp = 0.
  - startLtssm clears failCount, then GAP with target = detectQuiet.
  - forceDetect has no effect here.

Priorities and simultaneous events:
- forceDetect in GAP, WAIT, DECIDE or LINK goes to GAP with target = detectQuiet.
- It has priority over a finish or watchdog in the same cycle.
- It leaves failCount unchanged and clears linkUp and activeLanes.

Latency:
- After the edge that sets the second done flag, there is 1 cycle in DECIDE and 1 in GAP.
- The new target appears on substate 2 cycles after the DECIDE cycle begins.

Widths and arithmetic:
- failCount saturates at MAX_RETRIES.
- target+1 is computed in 4 bits; the target < cfgIdle guard prevents advancing past L0.

Decomposition:
- Shared package: substate localparams, NONE code, lpifStatus codes.
- One sub-module, ltssm_watchdog: a WD_WIDTH counter with clear/enable inputs and a terminal-count output.

Test Plan:
- Reset → startLtssm=1. Both sub-blocks reply exitTo = substate+1 with equal timing; lanes = 4. Expect substate sequence F,0,F,1,F,2…F,9,F,A; linkUp = 1, lpifStatus = 2, activeLanes = 4, failCount = 0.
- In pollingActive (2): rxExitTo = 3 at cycle t, txExitTo = 3 at t+5. Expect no transition before t+5, then F for 1 cycle, then substate = 3.
- In cfgLinkWidthStart (4): rx = 5, tx = 0 in the same cycle. Expect failCount = 1, then substate F, 0.
- 8 consecutive failures (MAX_RETRIES = 8). Expect FAILED, lpifStatus = 3, substate = F. A later startLtssm gives failCount = 0 and substate 0.
- detectActive success with numberOfDetectedLanes = 3. Expect fail path: failCount += 1, return to 0.
- In L0, pulse forceDetect. Expect linkUp = 0 next cycle, then F, 0. Assert reset mid-WAIT and expect all outputs at reset values.

Source files
------------

// File: rtl/ltssm_main_sequencer_pkg.sv
// Shared LTSSM encodings: substate codes, LPIF status codes and main sequencer states.
package ltssm_main_sequencer_pkg;

    localparam logic [3:0] SubDetectQuiet          = 4'd0;
    localparam logic [3:0] SubDetectActive         = 4'd1;
    localparam logic [3:0] SubPollingActive        = 4'd2;
    localparam logic [3:0] SubPollingConfiguration = 4'd3;
    localparam logic [3:0] SubCfgLinkWidthStart    = 4'd4;
    localparam logic [3:0] SubCfgLinkWidthAccept   = 4'd5;
    localparam logic [3:0] SubCfgLanenumWait       = 4'd6;
    localparam logic [3:0] SubCfgLanenumAccept     = 4'd7;
    localparam logic [3:0] SubCfgComplete          = 4'd8;
    localparam logic [3:0] SubCfgIdle              = 4'd9;
    localparam logic [3:0] SubL0                   = 4'd10;
    localparam logic [3:0] SubNone                 = 4'hF;

    localparam logic [3:0] LpifIdle     = 4'd0;
    localparam logic [3:0] LpifTraining = 4'd1;
    localparam logic [3:0] LpifActive   = 4'd2;
    localparam logic [3:0] LpifFailed   = 4'd3;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StWait,
        StDecide,
        StLink,
        StFailed
    } seqState_e;

    function automatic logic validLaneCount(input logic [4:0] lanes);
        case (lanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ltssm_main_sequencer_watchdog.sv
// Per-substate watchdog: free-running count while enabled, sticks at all-ones (terminal).
module ltssm_watchdog #(
    parameter int unsigned WD_WIDTH = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [WD_WIDTH-1:0] count;

    assign terminal = &count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ltssm_main_sequencer.sv
// Main LTSSM sequencer: issues substates to the RX/TX sub-LTSSMs, collects both replies,
// advances or retries training, and reports link status on the LPIF side.
module ltssm_main_sequencer
    import ltssm_main_sequencer_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = 8,
    parameter int unsigned WD_WIDTH    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startLtssm,
    input  logic       forceDetect,
    input  logic [4:0] numberOfDetectedLanes,
    input  logic       rxFinish,
    input  logic [3:0] rxExitTo,
    input  logic       txFinish,
    input  logic [3:0] txExitTo,
    output logic [3:0] substate,
    output logic [4:0] activeLanes,
    output logic       linkUp,
    output logic [3:0] lpifStatus,
    output logic [3:0] failCount
);

    localparam logic [3:0] MaxFails = 4'(MAX_RETRIES);

    seqState_e  state;
    logic [3:0] target;
    logic [3:0] rxExit;
    logic [3:0] txExit;
    logic       rxDone;
    logic       txDone;
    logic       wdTerminal;

    logic       bothDone;
    logic [3:0] nextTarget;
    logic       decideOk;
    logic       forceActive;
    logic       attemptFailed;
    logic [3:0] failInc;

    ltssm_watchdog #(
        .WD_WIDTH (WD_WIDTH)
    ) uWatchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == StGap),
        .enable   (state == StWait),
        .terminal (wdTerminal)
    );

    always_comb begin
        bothDone    = (rxDone || rxFinish) && (txDone || txFinish);
        nextTarget  = target + 4'd1;
        decideOk    = (rxExit == nextTarget) && (txExit == nextTarget) && (target <= SubCfgIdle)
                      && ((target != SubDetectActive) || validLaneCount(numberOfDetectedLanes));
        forceActive = forceDetect && (state inside {StGap, StWait, StDecide, StLink});
        attemptFailed = ((state == StWait) && !bothDone && wdTerminal)
                        || ((state == StDecide) && !decideOk);
        failInc     = (failCount >= MaxFails) ? failCount : failCount + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            target      <= SubDetectQuiet;
            substate    <= SubNone;
            rxDone      <= 1'b0;
            txDone      <= 1'b0;
            rxExit      <= 4'd0;
            txExit      <= 4'd0;
            activeLanes <= 5'd0;
            linkUp      <= 1'b0;
            lpifStatus  <= LpifIdle;
            failCount   <= 4'd0;
        end else if (forceActive) begin
            state       <= StGap;
            target      <= SubDetectQuiet;
            substate    <= SubNone;
            activeLanes <= 5'd0;
            linkUp      <= 1'b0;
            lpifStatus  <= LpifTraining;
        end else if (attemptFailed) begin
            failCount <= failInc;
            substate  <= SubNone;
            if (failInc == MaxFails) begin
                state      <= StFailed;
                lpifStatus <= LpifFailed;
            end else begin
                state  <= StGap;
                target <= SubDetectQuiet;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (startLtssm) begin
                        state      <= StGap;
                        target     <= SubDetectQuiet;
                        lpifStatus <= LpifTraining;
                    end
                end
                StFailed: begin
                    if (startLtssm) begin
                        failCount  <= 4'd0;
                        state      <= StGap;
                        target     <= SubDetectQuiet;
                        lpifStatus <= LpifTraining;
                    end
                end
                StGap: begin
                    rxDone <= 1'b0;
                    txDone <= 1'b0;
                    // cfgIdle success also passes through the gap, so L0 is a fresh request too
                    if (target == SubL0) begin
                        state      <= StLink;
                        substate   <= SubL0;
                        linkUp     <= 1'b1;
                        lpifStatus <= LpifActive;
                        failCount  <= 4'd0;
                    end else begin
                        state    <= StWait;
                        substate <= target;
                    end
                end
                StWait: begin
                    if (rxFinish && !rxDone) begin
                        rxDone <= 1'b1;
                        rxExit <= rxExitTo;
                    end
                    if (txFinish && !txDone) begin
                        txDone <= 1'b1;
                        txExit <= txExitTo;
                    end
                    if (bothDone) begin
                        state <= StDecide;
                    end
                end
                StDecide: begin
                    if (target == SubDetectActive) begin
                        activeLanes <= numberOfDetectedLanes;
                    end
                    target   <= nextTarget;
                    state    <= StGap;
                    substate <= SubNone;
                end
                StLink: begin
                end
                default: begin
                    state    <= StIdle;
                    substate <= SubNone;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltssm_main_sequencer.sv
// Self-checking bench: directed training scenarios plus randomized RX/TX responders,
// every cycle compared against a phase-level behavioural model.
module tb_ltssm_main_sequencer;

    localparam int MaxRetries = 8;
    localparam int WdWidth    = 5;
    localparam int WdLimit    = (1 << WdWidth) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startLtssm = 1'b0;
    logic       forceDetect = 1'b0;
    logic [4:0] lanes = 5'd4;
    logic       rxFinish = 1'b0;
    logic [3:0] rxExitTo = 4'd0;
    logic       txFinish = 1'b0;
    logic [3:0] txExitTo = 4'd0;
    logic [3:0] substate;
    logic [4:0] activeLanes;
    logic       linkUp;
    logic [3:0] lpifStatus;
    logic [3:0] failCount;

    always #5 clk = ~clk;

    ltssm_main_sequencer #(
        .MAX_RETRIES (MaxRetries),
        .WD_WIDTH    (WdWidth)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .startLtssm            (startLtssm),
        .forceDetect           (forceDetect),
        .numberOfDetectedLanes (lanes),
        .rxFinish              (rxFinish),
        .rxExitTo              (rxExitTo),
        .txFinish              (txFinish),
        .txExitTo              (txExitTo),
        .substate              (substate),
        .activeLanes           (activeLanes),
        .linkUp                (linkUp),
        .lpifStatus            (lpifStatus),
        .failCount             (failCount)
    );

    int compared = 0;
    int mismatched = 0;

    function automatic void chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum int {MIdle, MGap, MWait, MDecide, MLink, MFailed} mPhase_t;
    mPhase_t mPhase = MIdle;
    int mTarget = 0, mWaited = 0, mLanes = 0, mFails = 0;
    int mRxVal = 0, mTxVal = 0;
    bit mRxGot = 0, mTxGot = 0;

    function automatic int expSub();
        if (mPhase == MWait || mPhase == MDecide) return mTarget;
        if (mPhase == MLink) return 10;
        return 15;
    endfunction

    function automatic int expStatus();
        case (mPhase)
            MIdle:   return 0;
            MLink:   return 2;
            MFailed: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit laneOk(input int n);
        return n == 1 || n == 2 || n == 4 || n == 8 || n == 16;
    endfunction

    function automatic void modelFail();
        mFails = (mFails + 1 > MaxRetries) ? MaxRetries : mFails + 1;
        if (mFails == MaxRetries) mPhase = MFailed;
        else begin
            mPhase  = MGap;
            mTarget = 0;
        end
    endfunction

    function automatic void modelStep();
        bit timedOut;
        if (reset) begin
            mPhase = MIdle; mTarget = 0; mWaited = 0; mLanes = 0; mFails = 0;
            mRxGot = 0; mTxGot = 0; mRxVal = 0; mTxVal = 0;
            return;
        end
        if (forceDetect && mPhase inside {MGap, MWait, MDecide, MLink}) begin
            mPhase = MGap; mTarget = 0; mLanes = 0;
            return;
        end
        case (mPhase)
            MIdle: if (startLtssm) begin mPhase = MGap; mTarget = 0; end
            MFailed: if (startLtssm) begin mFails = 0; mPhase = MGap; mTarget = 0; end
            MGap: begin
                mRxGot = 0; mTxGot = 0; mWaited = 0;
                if (mTarget == 10) begin mPhase = MLink; mFails = 0; end
                else mPhase = MWait;
            end
            MWait: begin
                timedOut = (mWaited == WdLimit);
                if (rxFinish && !mRxGot) begin mRxGot = 1; mRxVal = int'(rxExitTo); end
                if (txFinish && !mTxGot) begin mTxGot = 1; mTxVal = int'(txExitTo); end
                if (mRxGot && mTxGot) mPhase = MDecide;
                else if (timedOut) modelFail();
                else mWaited++;
            end
            MDecide: begin
                if (mRxVal == mTarget + 1 && mTxVal == mTarget + 1 && mTarget <= 9
                    && (mTarget != 1 || laneOk(int'(lanes)))) begin
                    if (mTarget == 1) mLanes = int'(lanes);
                    mTarget = mTarget + 1;
                    mPhase  = MGap;
                end else modelFail();
            end
            default: ;
        endcase
    endfunction

    // ---------------- RX/TX responders ----------------
    bit randomMode = 0;
    int dRx[16], dTx[16], dRxEx[16], dTxEx[16];
    int prevSub = 15, rxCnt = -1, txCnt = -1, rxV = 0, txV = 0;
    int laneTab[8] = '{1, 2, 4, 8, 16, 3, 0, 4};

    bit tracing = 0;
    int trace[$];
    int cnt2 = 0;

    function automatic void resetKnobs();
        for (int i = 0; i < 16; i++) begin
            dRx[i] = 0; dTx[i] = 0; dRxEx[i] = -1; dTxEx[i] = -1;
        end
    endfunction

    function automatic void respond();
        int cur = expSub();
        if (cur != 15 && cur != 10 && cur != prevSub) begin
            if (randomMode) begin
                rxCnt = ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 6));
                txCnt = ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 6));
                rxV = ($urandom_range(0, 9) < 9) ? cur + 1 : int'($urandom_range(0, 15));
                txV = ($urandom_range(0, 9) < 9) ? cur + 1 : int'($urandom_range(0, 15));
            end else begin
                rxCnt = dRx[cur]; txCnt = dTx[cur];
                rxV = (dRxEx[cur] < 0) ? cur + 1 : dRxEx[cur];
                txV = (dTxEx[cur] < 0) ? cur + 1 : dTxEx[cur];
            end
        end
        prevSub  = cur;
        rxFinish = 1'b0;
        txFinish = 1'b0;
        rxExitTo = randomMode ? 4'($urandom_range(0, 15)) : 4'd0;
        txExitTo = randomMode ? 4'($urandom_range(0, 15)) : 4'd0;
        if (rxCnt == 0) begin rxFinish = 1'b1; rxExitTo = 4'(rxV); end
        else if (randomMode && rxCnt < 0 && $urandom_range(0, 19) == 0) rxFinish = 1'b1;
        if (txCnt == 0) begin txFinish = 1'b1; txExitTo = 4'(txV); end
        else if (randomMode && txCnt < 0 && $urandom_range(0, 19) == 0) txFinish = 1'b1;
        if (rxCnt >= 0) rxCnt--;
        if (txCnt >= 0) txCnt--;
    endfunction

    // One clock: drive inputs and advance the model, then compare away from the edge.
    task automatic step();
        if (randomMode) begin
            startLtssm  = ($urandom_range(0, 3) != 0);
            forceDetect = ($urandom_range(0, 149) == 0);
            reset       = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 19) == 0) lanes = 5'(laneTab[$urandom_range(0, 7)]);
        end
        respond();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        chk("substate", int'(substate), expSub());
        chk("linkUp", int'(linkUp), (mPhase == MLink) ? 1 : 0);
        chk("lpifStatus", int'(lpifStatus), expStatus());
        chk("activeLanes", int'(activeLanes), mLanes);
        chk("failCount", int'(failCount), mFails);
        if (tracing && (trace.size() == 0 || trace[$] != int'(substate))) trace.push_back(int'(substate));
        if (substate == 4'd2) cnt2++;
    endtask

    task automatic waitFor(input string name, input int sub, input int budget);
        int n = 0;
        while (int'(substate) != sub && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(substate), sub);
    endtask

    initial begin
        int n;
        int expTrace[$];
        resetKnobs();
        @(negedge clk);
        reset = 1'b1;
        step();
        step();

        // Clean training run to L0 with four lanes
        reset = 1'b0;
        tracing = 1;
        startLtssm = 1'b1;
        waitFor("reach_l0", 10, 200);
        tracing = 0;
        for (int k = 0; k < 10; k++) begin
            expTrace.push_back(15);
            expTrace.push_back(k);
        end
        expTrace.push_back(15);
        expTrace.push_back(10);
        chk("trace_len", trace.size(), expTrace.size());
        for (int i = 0; i < expTrace.size() && i < trace.size(); i++)
            chk("trace_entry", trace[i], expTrace[i]);
        chk("l0_linkUp", int'(linkUp), 1);
        chk("l0_status", int'(lpifStatus), 2);
        chk("l0_lanes", int'(activeLanes), 4);
        chk("l0_failCount", int'(failCount), 0);

        // forceDetect from L0
        startLtssm = 1'b0;
        forceDetect = 1'b1;
        step();
        forceDetect = 1'b0;
        chk("force_linkDown", int'(linkUp), 0);
        chk("force_gap", int'(substate), 15);
        chk("force_lanes", int'(activeLanes), 0);
        step();
        chk("force_then_dq", int'(substate), 0);

        // pollingActive: TX answers five cycles after RX
        dTx[2] = 5;
        cnt2 = 0;
        waitFor("reach_pcfg", 3, 100);
        chk("polling_cycles", cnt2, 7);

        // cfgLinkWidthStart: TX exits to 0
        dTxEx[4] = 0;
        waitFor("fail_to_dq", 0, 100);
        chk("fail_count_1", int'(failCount), 1);

        // Every attempt fails until the retry limit
        for (int i = 0; i < 16; i++) dTxEx[i] = 0;
        n = 0;
        while (lpifStatus != 4'd3 && n < 500) begin
            step();
            n++;
        end
        chk("failed_status", int'(lpifStatus), 3);
        chk("failed_count", int'(failCount), 8);
        chk("failed_sub", int'(substate), 15);
        step();
        chk("failed_holds", int'(lpifStatus), 3);
        resetKnobs();
        startLtssm = 1'b1;
        step();
        startLtssm = 1'b0;
        chk("restart_count", int'(failCount), 0);
        chk("restart_status", int'(lpifStatus), 1);
        waitFor("restart_dq", 0, 10);

        // Illegal lane count at detectActive
        lanes = 5'd3;
        waitFor("bad_lanes_da", 1, 50);
        waitFor("bad_lanes_dq", 0, 50);
        chk("bad_lanes_count", int'(failCount), 1);
        chk("bad_lanes_keep", int'(activeLanes), 4);

        // Reset in the middle of a WAIT
        lanes = 5'd4;
        dRx[3] = 20;
        dTx[3] = 20;
        waitFor("reach_wait3", 3, 100);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_sub", int'(substate), 15);
        chk("rst_linkUp", int'(linkUp), 0);
        chk("rst_status", int'(lpifStatus), 0);
        chk("rst_count", int'(failCount), 0);
        chk("rst_lanes", int'(activeLanes), 0);

        // Randomized traffic against the model
        randomMode = 1;
        for (int i = 0; i < 4000; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
